// File: rtl/ram_loader.sv
// ram_loader: initiator for a RAM16K-style port (combinational read,
// write on posedge). LOAD streams words into consecutive locations,
// DUMP streams consecutive words out through a one-entry output register.
module ram_loader #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_load,
   input  logic [DATA_W-1:0] mem_out,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] addr_reg;
   // Words still to be written (LOAD) or still to be fetched (DUMP).
   logic [ADDR_W:0]   cnt_reg;
   logic              rd_valid_reg;
   logic [DATA_W-1:0] rd_data_reg;

   logic cmd_fire;
   logic wr_fire;
   logic rd_fire;
   logic fetch;

   assign cmd_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_DONE);
   assign wr_ready  = (state_reg == ST_LOAD);

   // The write is driven straight from the handshake so it lands on the
   // same edge that consumes the word; it falls with the async reset.
   assign mem_load  = wr_ready & wr_valid;
   assign mem_in    = wr_data;
   assign mem_addr  = addr_reg;

   assign rd_valid  = rd_valid_reg;
   assign rd_data   = rd_data_reg;

   assign cmd_fire  = cmd_valid & cmd_ready;
   assign wr_fire   = mem_load;
   assign rd_fire   = rd_valid_reg & rd_ready;
   // Refill the output register whenever it is empty or being drained.
   assign fetch     = (state_reg == ST_DUMP) & (~rd_valid_reg | rd_ready) &
                      (cnt_reg != '0);

   // Transfer sequencing: command capture, address walk, output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         cnt_reg      <= '0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_fire) begin
                  addr_reg <= cmd_base;
                  cnt_reg  <= cmd_len;
                  if (cmd_len == '0) begin
                     state_reg <= ST_DONE;
                  end else if (cmd_op) begin
                     state_reg <= ST_DUMP;
                  end else begin
                     state_reg <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (wr_fire) begin
                  addr_reg <= addr_reg + 1'b1;
                  cnt_reg  <= cnt_reg - 1'b1;
                  if (cnt_reg == CNT_ONE) begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_DUMP: begin
               if (fetch) begin
                  rd_data_reg  <= mem_out;
                  rd_valid_reg <= 1'b1;
                  addr_reg     <= addr_reg + 1'b1;
                  cnt_reg      <= cnt_reg - 1'b1;
               end else if (rd_fire) begin
                  // Nothing left to fetch: this was the final word.
                  rd_valid_reg <= 1'b0;
                  state_reg    <= ST_DONE;
               end
            end
            default: begin
               rd_valid_reg <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
